// File: rtl/axi_lite_gpio_pkg.sv
// Shared register indices, response codes and byte-strobe merge helper for
// the axi_lite_gpio_slave peripheral.
package axi_lite_gpio_pkg;

   localparam logic [1:0] REG_OUT     = 2'd0;
   localparam logic [1:0] REG_IN      = 2'd1;
   localparam logic [1:0] REG_SCRATCH = 2'd2;
   localparam logic [1:0] REG_TIMER   = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

// File: rtl/axi_lite_gpio_slave_sync.sv
// Parameterised-width two-flop synchronizer with synchronous active-high reset.
module gpio_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite GPIO responder: OUT, synchronized IN, SCRATCH and TIMER registers.
// Define AXI_GPIO_TIMER_EN to build the free-running TIMER; otherwise 0xC reads 0.
module axi_lite_gpio_slave
   import axi_lite_gpio_pkg::*;
#(
   parameter logic [31:0] OUT_RESET     = 32'h0000_0000,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [3:0]  AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   input  logic [31:0] GPIO_IN,
   output logic [31:0] GPIO_OUT
);

   logic        aw_held_q, aw_held_d;
   logic        w_held_q, w_held_d;
   logic [1:0]  awidx_q, awidx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] out_q, out_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] gpio_in_sync;
   logic [31:0] timer_rd;
   logic [31:0] rd_val;
   logic        aw_fire, w_fire, ar_fire, commit;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^{ARADDR[1:0], AWADDR[1:0]};

   gpio_sync #(.WIDTH(32)) u_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (GPIO_IN),
      .q_o   (gpio_in_sync)
   );

   assign AWREADY = !aw_held_q && !bvalid_q && !RST;
   assign WREADY  = !w_held_q && !bvalid_q && !RST;
   assign ARREADY = !rvalid_q && !RST;

   assign aw_fire = AWVALID && AWREADY;
   assign w_fire  = WVALID && WREADY;
   assign ar_fire = ARVALID && ARREADY;
   assign commit  = aw_held_q && w_held_q;

`ifdef AXI_GPIO_TIMER_EN
   logic [31:0] timer_q;
   logic        timer_clr;

   always_ff @(posedge CLK) begin
      if (RST) timer_q <= '0;
      else     timer_q <= timer_clr ? 32'd0 : timer_q + 32'd1;
   end

   assign timer_rd = timer_q;
`else
   assign timer_rd = 32'd0;
`endif

   always_comb begin
      case (ARADDR[3:2])
         REG_OUT:     rd_val = out_q;
         REG_IN:      rd_val = gpio_in_sync;
         REG_SCRATCH: rd_val = scratch_q;
         default:     rd_val = timer_rd;
      endcase
   end

   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awidx_d   = awidx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      out_d     = out_q;
      scratch_d = scratch_q;
`ifdef AXI_GPIO_TIMER_EN
      timer_clr = 1'b0;
`endif

      if (aw_fire) begin
         aw_held_d = 1'b1;
         awidx_d   = AWADDR[3:2];
      end
      if (w_fire) begin
         w_held_d = 1'b1;
         wdata_d  = WDATA;
         wstrb_d  = WSTRB;
      end
      if (bvalid_q && BREADY) bvalid_d = 1'b0;

      // Commit only happens with BVALID low, since no AW/W is accepted while it is high.
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_OKAY;
         case (awidx_q)
            REG_OUT:     out_d     = apply_wstrb(out_q, wdata_q, wstrb_q);
            REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, wdata_q, wstrb_q);
            REG_IN:      bresp_d   = RESP_SLVERR;
`ifdef AXI_GPIO_TIMER_EN
            default:     timer_clr = 1'b1;
`else
            default:     bresp_d   = RESP_SLVERR;
`endif
         endcase
      end

      if (rvalid_q && RREADY) rvalid_d = 1'b0;
      if (ar_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
         rresp_d  = RESP_OKAY;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         out_q     <= OUT_RESET;
         scratch_q <= SCRATCH_RESET;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         out_q     <= out_d;
         scratch_q <= scratch_d;
      end
   end

   // Held write payload is qualified by the flags, so it needs no reset.
   always_ff @(posedge CLK) begin
      awidx_q <= awidx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end

   assign RDATA    = rdata_q;
   assign RRESP    = rresp_q;
   assign RVALID   = rvalid_q;
   assign BRESP    = bresp_q;
   assign BVALID   = bvalid_q;
   assign GPIO_OUT = out_q;

endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// Scoreboard bench for axi_lite_gpio_slave: stimulus pushes expected R/B
// responses, a negedge monitor pops and compares them.
module tb_axi_lite_gpio_slave;
   import axi_lite_gpio_pkg::*;

   localparam logic [31:0] OUT_RST = 32'h0F0F_1234;
   localparam logic [31:0] SCR_RST = 32'hCAFE_0001;

   logic        CLK, RST;
   logic [3:0]  ARADDR, AWADDR;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] RDATA, WDATA, GPIO_IN, GPIO_OUT;
   logic [1:0]  RRESP, BRESP;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [3:0]  WSTRB;

   axi_lite_gpio_slave #(.OUT_RESET(OUT_RST), .SCRATCH_RESET(SCR_RST)) dut (
      .CLK(CLK), .RST(RST),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rexp_q[$];
   logic [1:0]  rrexp_q[$];
   logic [1:0]  bexp_q[$];

   // Reference register image
   logic [31:0] out_m, scr_m, gpio_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   // Monitor
   logic        prev_rhold, prev_bhold;
   logic [31:0] prev_rdata, e_d;
   logic [1:0]  prev_rresp, prev_bresp, e_r;

   initial begin
      prev_rhold = 1'b0;
      prev_bhold = 1'b0;
      prev_rdata = '0;
      prev_rresp = '0;
      prev_bresp = '0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            prev_rhold = 1'b0;
            prev_bhold = 1'b0;
         end else begin
            if (RVALID) begin
               chk("arready_low_while_rvalid", 32'(ARREADY), 32'd0);
               if (prev_rhold) begin
                  chk("rdata_stable", RDATA, prev_rdata);
                  chk("rresp_stable", 32'(RRESP), 32'(prev_rresp));
               end
               if (RREADY) begin
                  if (rexp_q.size() == 0) fail_now("r_unexpected");
                  else begin
                     e_d = rexp_q.pop_front();
                     e_r = rrexp_q.pop_front();
                     chk("rdata", RDATA, e_d);
                     chk("rresp", 32'(RRESP), 32'(e_r));
                  end
               end
            end
            prev_rhold = RVALID && !RREADY;
            prev_rdata = RDATA;
            prev_rresp = RRESP;

            if (BVALID) begin
               chk("aw_w_blocked_while_bvalid", 32'({AWREADY, WREADY}), 32'd0);
               if (prev_bhold) chk("bresp_stable", 32'(BRESP), 32'(prev_bresp));
               if (BREADY) begin
                  if (bexp_q.size() == 0) fail_now("b_unexpected");
                  else begin
                     e_r = bexp_q.pop_front();
                     chk("bresp", 32'(BRESP), 32'(e_r));
                  end
               end
            end
            prev_bhold = BVALID && !BREADY;
            prev_bresp = BRESP;
         end
      end
   end

   task automatic wait_b(input int bdly);
      int guard;
      guard = 0;
      @(negedge CLK);
      while (!BVALID && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      if (!BVALID) begin
         fail_now("b_timeout");
         BREADY = 1'b1;
         return;
      end
      if (!BREADY) begin
         repeat (bdly) @(posedge CLK);
         #1 BREADY = 1'b1;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_r(input int rdly);
      int guard;
      guard = 0;
      @(negedge CLK);
      while (!RVALID && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      if (!RVALID) begin
         fail_now("r_timeout");
         RREADY = 1'b1;
         return;
      end
      if (!RREADY) begin
         repeat (rdly) @(posedge CLK);
         #1 RREADY = 1'b1;
      end
      @(posedge CLK);
      #1;
   endtask

   // order: 0 = AW and W together, 1 = W three cycles before AW, 2 = AW three cycles before W
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int bdly, input bit chk_lat);
      logic [1:0] exp;
      logic awf, wf, aw_done, w_done;
      int gap, guard;
      exp = RESP_OKAY;
      case (addr[3:2])
         2'd0: out_m = merge(out_m, data, strb);
         2'd1: exp = RESP_SLVERR;
         2'd2: scr_m = merge(scr_m, data, strb);
         default: begin
`ifdef AXI_GPIO_TIMER_EN
            exp = RESP_OKAY;
`else
            exp = RESP_SLVERR;
`endif
         end
      endcase
      bexp_q.push_back(exp);
      BREADY = (bdly == 0);
      AWADDR = addr;
      WDATA = data;
      WSTRB = strb;
      aw_done = 1'b0;
      w_done = 1'b0;
      AWVALID = (order != 1);
      WVALID = (order != 2);
      gap = 0;
      guard = 0;
      while (!(aw_done && w_done)) begin
         @(negedge CLK);
         awf = AWVALID && AWREADY;
         wf = WVALID && WREADY;
         @(posedge CLK);
         #1;
         if (awf) begin AWVALID = 1'b0; aw_done = 1'b1; end
         if (wf) begin WVALID = 1'b0; w_done = 1'b1; end
         if (order == 1 && w_done && !aw_done && !AWVALID) begin
            gap++;
            if (gap >= 3) AWVALID = 1'b1;
         end
         if (order == 2 && aw_done && !w_done && !WVALID) begin
            gap++;
            if (gap >= 3) WVALID = 1'b1;
         end
         guard++;
         if (guard > 50) begin
            fail_now("aw_w_handshake_timeout");
            AWVALID = 1'b0;
            WVALID = 1'b0;
            return;
         end
      end
      if (chk_lat) begin
         @(negedge CLK);
         chk("bvalid_after_1_edge", 32'(BVALID), 32'd0);
         @(negedge CLK);
         chk("bvalid_after_2_edges", 32'(BVALID), 32'd1);
         @(posedge CLK);
         #1;
      end else begin
         wait_b(bdly);
      end
      chk("gpio_out", GPIO_OUT, out_m);
   endtask

   task automatic do_read_exp(input logic [3:0] addr, input logic [31:0] exp, input int rdly);
      int guard;
      rexp_q.push_back(exp);
      rrexp_q.push_back(RESP_OKAY);
      RREADY = (rdly == 0);
      ARADDR = addr;
      ARVALID = 1'b1;
      guard = 0;
      @(negedge CLK);
      while (!ARREADY && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      if (!ARREADY) begin
         fail_now("ar_timeout");
         ARVALID = 1'b0;
         return;
      end
      @(posedge CLK);
      #1 ARVALID = 1'b0;
      wait_r(rdly);
   endtask

   task automatic do_read(input logic [3:0] addr, input int rdly);
      logic [31:0] exp;
      case (addr[3:2])
         2'd0: exp = out_m;
         2'd1: exp = gpio_m;
         2'd2: exp = scr_m;
         default: exp = 32'd0;
      endcase
      do_read_exp(addr, exp, rdly);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   logic [31:0] old_v, new_v, d;
   logic [3:0]  a, s;
   int op;

   initial begin
      RST = 1'b1;
      ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
      AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      GPIO_IN = '0;
      out_m = OUT_RST;
      scr_m = SCR_RST;
      gpio_m = '0;

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_arready", 32'(ARREADY), 32'd0);
      chk("rst_awready", 32'(AWREADY), 32'd0);
      chk("rst_wready", 32'(WREADY), 32'd0);
      chk("rst_rvalid", 32'(RVALID), 32'd0);
      chk("rst_bvalid", 32'(BVALID), 32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      chk("rst_rresp", 32'(RRESP), 32'd0);
      chk("rst_bresp", 32'(BRESP), 32'd0);
      chk("rst_gpio_out", GPIO_OUT, OUT_RST);
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_awready", 32'(AWREADY), 32'd1);
      chk("post_rst_arready", 32'(ARREADY), 32'd1);
      @(posedge CLK);
      #1;
      do_read(4'h8, 0);
      do_read(4'h0, 1);

      // AW+W same cycle to OUT
      do_write(4'h0, 32'hA5A5_5A5A, 4'hF, 0, 0, 1'b1);

      // W ahead of AW, partial strobe, B held for 4 cycles
      do_write(4'h8, 32'h0000_0000, 4'hF, 0, 0, 1'b0);
      do_write(4'h8, 32'h1122_3344, 4'b0101, 1, 4, 1'b0);
      do_read(4'hA, 0);

      // Synchronized input, R held for 2 cycles
      GPIO_IN = 32'hDEAD_BEEF;
      gpio_m = 32'hDEAD_BEEF;
      repeat (3) @(posedge CLK);
      #1;
      do_read(4'h4, 2);

      // Write to read-only IN
      do_write(4'h4, 32'h1234_5678, 4'hF, 0, 0, 1'b0);
      do_read(4'h4, 0);

      // Read in the commit cycle of a write to the same register
      old_v = scr_m;
      new_v = $urandom;
      scr_m = new_v;
      bexp_q.push_back(RESP_OKAY);
      rexp_q.push_back(old_v);
      rrexp_q.push_back(RESP_OKAY);
      BREADY = 1'b1; RREADY = 1'b1;
      AWADDR = 4'h8; WDATA = new_v; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      @(negedge CLK);
      chk("aw_w_ready_idle", 32'({AWREADY, WREADY}), 32'd3);
      @(posedge CLK);
      #1 AWVALID = 1'b0; WVALID = 1'b0; ARADDR = 4'h8; ARVALID = 1'b1;
      @(negedge CLK);
      chk("arready_in_commit_cycle", 32'(ARREADY), 32'd1);
      @(posedge CLK);
      #1 ARVALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      do_read(4'h8, 0);

`ifdef AXI_GPIO_TIMER_EN
      do_write(4'hC, $urandom, 4'b0000, 0, 0, 1'b0);
      do_read_exp(4'hC, 32'd1, 0);
      @(negedge CLK);
      force dut.timer_q = 32'hFFFF_FFFF;
      @(posedge CLK);
      #1 release dut.timer_q;
      @(negedge CLK);
      chk("timer_forced", dut.timer_q, 32'hFFFF_FFFF);
      @(negedge CLK);
      chk("timer_wrap", dut.timer_q, 32'd0);
      @(posedge CLK);
      #1;
`else
      do_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0);
      do_read(4'hC, 0);
`endif

      // Reset with AW held and W outstanding
      BREADY = 1'b1;
      AWADDR = 4'h0; AWVALID = 1'b1;
      @(negedge CLK);
      @(posedge CLK);
      #1 AWVALID = 1'b0;
      @(negedge CLK);
      chk("awready_low_when_held", 32'(AWREADY), 32'd0);
      @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      out_m = OUT_RST;
      scr_m = SCR_RST;
      @(negedge CLK);
      chk("midrst_awready", 32'(AWREADY), 32'd1);
      chk("midrst_gpio_out", GPIO_OUT, OUT_RST);
      repeat (3) begin
         @(negedge CLK);
         chk("midrst_no_bvalid", 32'(BVALID), 32'd0);
      end
      @(posedge CLK);
      #1;
      do_read(4'h8, 0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         op = $urandom_range(0, 9);
         if (op < 4) begin
            a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            d = $urandom;
            s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
         end else if (op < 8) begin
`ifdef AXI_GPIO_TIMER_EN
            a = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
`else
            a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
`endif
            do_read(a, $urandom_range(0, 3));
         end else begin
            GPIO_IN = $urandom;
            gpio_m = GPIO_IN;
            repeat (3) @(posedge CLK);
            #1;
         end
      end

      repeat (5) @(posedge CLK);
      #1;
      chk("r_queue_drained", 32'(rexp_q.size()), 32'd0);
      chk("b_queue_drained", 32'(bexp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
